// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single external memory port: I-cache refill vs D-cache.
// Holds the port for one owner across back-to-back words, up to MAX_BURST, then round-robins.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_BURST   = 16,
  parameter int BURST_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ic_req,
  input  logic [ADDR_WIDTH-1:0]   ic_addr,
  output logic                    ic_done,
  output logic [DATA_WIDTH-1:0]   ic_rdata,
  input  logic                    dc_req,
  input  logic                    dc_we,
  input  logic [ADDR_WIDTH-1:0]   dc_addr,
  input  logic [DATA_WIDTH-1:0]   dc_wdata,
  input  logic [DATA_WIDTH/8-1:0] dc_wmask,
  output logic                    dc_done,
  output logic [DATA_WIDTH-1:0]   dc_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_done,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy_owner
);

  localparam logic [BURST_WIDTH-1:0] BURST_MAX = BURST_WIDTH'(MAX_BURST);
  localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

  typedef enum logic {ARB, BUSY} state_t;

  state_t                 state;
  logic                   last_grant;
  logic                   lock;
  logic                   aborted;
  logic [BURST_WIDTH-1:0] burst_cnt;

  logic                   any_req;
  logic                   locked_req;
  logic                   other_req;
  logic                   owner_req;
  logic                   grant_owner;
  logic [BURST_WIDTH-1:0] grant_cnt;

  function automatic logic [BURST_WIDTH-1:0] sat_inc(input logic [BURST_WIDTH-1:0] c);
    return (c < BURST_MAX) ? c + BURST_ONE : BURST_MAX;
  endfunction

  // Owner selection: the locked owner keeps the port until its burst budget is spent
  always_comb begin
    any_req     = ic_req | dc_req;
    locked_req  = lock & (last_grant ? dc_req : ic_req);
    other_req   = last_grant ? ic_req : dc_req;
    owner_req   = busy_owner ? dc_req : ic_req;
    grant_owner = 1'b0;
    grant_cnt   = BURST_ONE;
    if (locked_req) begin
      if (burst_cnt < BURST_MAX) begin
        grant_owner = last_grant;
        grant_cnt   = sat_inc(burst_cnt);
      end else if (other_req) begin
        grant_owner = ~last_grant;
      end else begin
        grant_owner = last_grant;
      end
    end else if (ic_req && dc_req) begin
      grant_owner = ~last_grant;
    end else begin
      grant_owner = dc_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      busy_owner <= 1'b0;
      ic_done    <= 1'b0;
      dc_done    <= 1'b0;
      ic_rdata   <= '0;
      dc_rdata   <= '0;
      last_grant <= 1'b1;
      lock       <= 1'b0;
      aborted    <= 1'b0;
      burst_cnt  <= '0;
    end else begin
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      case (state)
        ARB: begin
          if (any_req) begin
            state      <= BUSY;
            mem_req    <= 1'b1;
            busy_owner <= grant_owner;
            last_grant <= grant_owner;
            lock       <= 1'b1;
            aborted    <= 1'b0;
            burst_cnt  <= grant_cnt;
            if (grant_owner) begin
              mem_we    <= dc_we;
              mem_addr  <= dc_addr;
              mem_wdata <= dc_wdata;
              mem_wmask <= dc_wmask;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= ic_addr;
              mem_wdata <= '0;
              mem_wmask <= '0;
            end
          end
        end
        BUSY: begin
          // A requester that lets go mid-op has cancelled it; the op still drains
          if (!owner_req) aborted <= 1'b1;
          if (mem_done) begin
            state   <= ARB;
            mem_req <= 1'b0;
            if (aborted || !owner_req) begin
              lock <= 1'b0;
            end else if (busy_owner) begin
              dc_done  <= 1'b1;
              dc_rdata <= mem_rdata;
            end else begin
              ic_done  <= 1'b1;
              ic_rdata <= mem_rdata;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory commands and
// completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_done;
  logic [31:0] ic_rdata;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [31:0] dc_addr = '0;
  logic [31:0] dc_wdata = '0;
  logic [3:0]  dc_wmask = '0;
  logic        dc_done;
  logic [31:0] dc_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        busy_owner;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(16), .BURST_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wmask(dc_wmask), .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy_owner(busy_owner)
  );

  typedef struct {
    logic        owner;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          exp_cyc;   // >=0 absolute issue cycle, -2: two cycles after previous mem_done
  } cmd_t;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_md = -100;
  logic rst_e = 1'b1;
  int   lat = 1;
  int   spur_req = 0;
  int   timeouts = 0;
  bit   tb_end = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_e <= rst;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hC3A5_0F0F;
  endfunction

  // Memory model: answers each op after lat cycles of mem_req, reset alongside the DUT
  initial begin : mem_model
    int wcnt = 0;
    int spur_seen = 0;
    mem_done  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_done = 1'b0;
      if (rst_e || !mem_req) wcnt = 0;
      if (!rst_e && mem_req) begin
        wcnt++;
        if (wcnt >= lat) begin
          mem_done  = 1'b1;
          mem_rdata = mem_fn(mem_addr);
          wcnt      = 0;
        end
      end else if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        mem_done  = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  task automatic check_rsp(input logic owner, input logic [31:0] rd);
    rsp_t r;
    checks++;
    if (rsp_q.size() == 0) begin
      errors++;
      $display("FAIL done_unexpected owner=%0d rdata=%h cyc=%0d", owner, rd, cyc);
    end else begin
      r = rsp_q.pop_front();
      if (r.owner !== owner || r.rdata !== rd) begin
        errors++;
        $display("FAIL done_resp owner got %0d exp %0d rdata got %h exp %h",
                 owner, r.owner, rd, r.rdata);
      end
      checks++;
      if (cyc != last_md + 1) begin
        errors++;
        $display("FAIL done_latency got cyc %0d exp %0d", cyc, last_md + 1);
      end
    end
  endtask

  task automatic check_cmd();
    cmd_t e;
    checks++;
    if (cmd_q.size() == 0) begin
      errors++;
      $display("FAIL cmd_unexpected owner=%0d addr=%h cyc=%0d", busy_owner, mem_addr, cyc);
    end else begin
      e = cmd_q.pop_front();
      if (busy_owner !== e.owner || mem_addr !== e.addr || mem_we !== e.we ||
          mem_wmask !== e.wmask || (e.owner && mem_wdata !== e.wdata)) begin
        errors++;
        $display("FAIL cmd_fields got own=%0d a=%h we=%0d wd=%h m=%h exp own=%0d a=%h we=%0d wd=%h m=%h",
                 busy_owner, mem_addr, mem_we, mem_wdata, mem_wmask,
                 e.owner, e.addr, e.we, e.wdata, e.wmask);
      end
      if (e.exp_cyc != -1) begin
        checks++;
        if (cyc != ((e.exp_cyc == -2) ? last_md + 2 : e.exp_cyc)) begin
          errors++;
          $display("FAIL cmd_issue_cycle got %0d exp %0d", cyc,
                   (e.exp_cyc == -2) ? last_md + 2 : e.exp_cyc);
        end
      end
    end
  endtask

  initial begin : monitor
    logic        prev_req = 1'b0;
    logic [69:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst_e) begin
        checks++;
        if ({mem_req, mem_we, ic_done, dc_done, busy_owner} !== 5'b0 || mem_addr !== '0 ||
            mem_wmask !== '0) begin
          errors++;
          $display("FAIL reset_state req=%0d we=%0d icd=%0d dcd=%0d own=%0d addr=%h",
                   mem_req, mem_we, ic_done, dc_done, busy_owner, mem_addr);
        end
      end
      if (!rst_e && mem_req && !prev_req) begin
        check_cmd();
        held = {mem_we, busy_owner, mem_addr, mem_wmask, mem_wdata};
      end else if (mem_req && prev_req) begin
        checks++;
        if ({mem_we, busy_owner, mem_addr, mem_wmask, mem_wdata} !== held) begin
          errors++;
          $display("FAIL cmd_stable got %h exp %h",
                   {mem_we, busy_owner, mem_addr, mem_wmask, mem_wdata}, held);
        end
      end
      if (ic_done && dc_done) begin
        checks++;
        errors++;
        $display("FAIL both_done got 1 1 exp one");
      end
      if (ic_done) check_rsp(1'b0, ic_rdata);
      if (dc_done) check_rsp(1'b1, dc_rdata);
      if (mem_req && mem_done) last_md = cyc;
      prev_req = mem_req;
      if (tb_end || cyc > 20000) begin
        checks++;
        if (!tb_end) begin
          errors++;
          $display("FAIL watchdog got cyc %0d exp end", cyc);
        end
        checks++;
        if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
          errors++;
          $display("FAIL leftover got cmd %0d rsp %0d exp 0 0", cmd_q.size(), rsp_q.size());
        end
        checks++;
        if (timeouts != 0) begin
          errors++;
          $display("FAIL wait_timeout got %0d exp 0", timeouts);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input logic o, input logic [31:0] a, input logic we,
                          input logic [31:0] wd, input logic [3:0] m, input int ec);
    cmd_t c;
    c.owner = o; c.addr = a; c.we = we; c.wdata = wd; c.wmask = m; c.exp_cyc = ec;
    cmd_q.push_back(c);
  endtask

  task automatic push_rsp(input logic o, input logic [31:0] a);
    rsp_t r;
    r.owner = o; r.rdata = mem_fn(a);
    rsp_q.push_back(r);
  endtask

  task automatic wait_done(input logic owner);
    int t = 0;
    do begin
      tick();
      t++;
    end while (!(owner ? dc_done : ic_done) && t < 300);
    if (t >= 300) timeouts++;
  endtask

  task automatic ic_refill(input logic [31:0] base, input int n);
    ic_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      ic_addr = base + 32'(4 * i);
      wait_done(1'b0);
    end
    ic_req = 1'b0;
  endtask

  task automatic dc_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m);
    dc_we = we; dc_addr = a; dc_wdata = wd; dc_wmask = m;
    dc_req = 1'b1;
    wait_done(1'b1);
    dc_req = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((cmd_q.size() != 0 || rsp_q.size() != 0 || mem_req) && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) timeouts++;
    tick();
    tick();
  endtask

  initial begin : stimulus
    int c;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Tie out of reset: I-cache burst of 4 first, D-cache write next
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      push_cmd(1'b0, 32'h1000 + 32'(4 * i), 1'b0, 32'h0, 4'h0, (i == 0) ? c + 1 : -2);
      push_rsp(1'b0, 32'h1000 + 32'(4 * i));
    end
    push_cmd(1'b1, 32'h500, 1'b1, 32'h1122_3344, 4'h3, -2);
    push_rsp(1'b1, 32'h500);
    fork
      ic_refill(32'h1000, 4);
      dc_op(1'b1, 32'h500, 32'h1122_3344, 4'h3);
    join
    wait_idle();

    // Single D-cache write, memory answers 3 cycles after mem_req
    lat = 4;
    tick();
    c = cyc;
    push_cmd(1'b1, 32'h100, 1'b1, 32'hDEAD_BEEF, 4'hF, c + 1);
    push_rsp(1'b1, 32'h100);
    dc_op(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    wait_idle();

    // Full 16-word I-cache refill with single-cycle memory
    lat = 1;
    tick();
    c = cyc;
    for (int i = 0; i < 16; i++) begin
      push_cmd(1'b0, 32'h2000 + 32'(4 * i), 1'b0, 32'h0, 4'h0, (i == 0) ? c + 1 : -2);
      push_rsp(1'b0, 32'h2000 + 32'(4 * i));
    end
    ic_refill(32'h2000, 16);
    wait_idle();

    // Fairness: 20-word I-cache stream, D-cache read arrives during word 3
    c = cyc;
    for (int i = 0; i < 20; i++) begin
      if (i == 16) begin
        push_cmd(1'b1, 32'h600, 1'b0, 32'h0, 4'h0, -2);
        push_rsp(1'b1, 32'h600);
      end
      push_cmd(1'b0, 32'h4000 + 32'(4 * i), 1'b0, 32'h0, 4'h0, (i == 0) ? c + 1 : -2);
      push_rsp(1'b0, 32'h4000 + 32'(4 * i));
    end
    fork
      ic_refill(32'h4000, 20);
      begin
        int seen = 0;
        int t = 0;
        while (seen < 2 && t < 300) begin
          tick();
          t++;
          if (ic_done) seen++;
        end
        if (t >= 300) timeouts++;
        dc_op(1'b0, 32'h600, 32'h0, 4'h0);
      end
    join
    wait_idle();

    // Abort: I-cache drops req one cycle after grant, pending D-cache read follows
    lat = 6;
    tick();
    c = cyc;
    push_cmd(1'b0, 32'h3000, 1'b0, 32'h0, 4'h0, c + 1);
    push_cmd(1'b1, 32'h700, 1'b0, 32'h0, 4'h0, -2);
    push_rsp(1'b1, 32'h700);
    ic_addr = 32'h3000;
    ic_req  = 1'b1;
    dc_we = 1'b0; dc_addr = 32'h700; dc_wdata = '0; dc_wmask = '0;
    dc_req  = 1'b1;
    tick();
    tick();
    ic_req = 1'b0;
    wait_done(1'b1);
    dc_req = 1'b0;
    wait_idle();

    // Reset mid-op, late spurious mem_done, then a tie that must go to the I-cache
    lat = 20;
    tick();
    c = cyc;
    push_cmd(1'b0, 32'h3100, 1'b0, 32'h0, 4'h0, c + 1);
    ic_addr = 32'h3100;
    ic_req  = 1'b1;
    repeat (3) tick();
    rst    = 1'b1;
    ic_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    spur_req = spur_req + 1;
    repeat (4) tick();
    lat = 1;
    tick();
    c = cyc;
    push_cmd(1'b0, 32'h3200, 1'b0, 32'h0, 4'h0, c + 1);
    push_rsp(1'b0, 32'h3200);
    push_cmd(1'b1, 32'h800, 1'b0, 32'h0, 4'h0, -2);
    push_rsp(1'b1, 32'h800);
    fork
      ic_refill(32'h3200, 1);
      dc_op(1'b0, 32'h800, 32'h0, 4'h0);
    join
    wait_idle();

    tb_end = 1'b1;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external memory port between the instruction cache refill path and the data cache / load-store path.
- Latches one word operation at a time and forwards it to memory. Routes the completion pulse and read data back to the owning requester.
- Holds the port for a requester across consecutive words, for example a full 16-word I-cache line refill, up to a burst limit. After the limit, round-robin arbitration gives the other side a turn.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width
MAX_BURST, 16, max back-to-back ops granted to one owner while the other side waits
BURST_WIDTH, 5, counter width; must hold MAX_BURST

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ic_req  in  1  I-cache op request, level-held
ic_addr  in  ADDR_WIDTH  I-cache word address
ic_done  out  1  1-cycle pulse: I-cache op complete
ic_rdata  out  DATA_WIDTH  read data, valid with ic_done
dc_req  in  1  D-cache op request, level-held
dc_we  in  1  1 = write, 0 = read
dc_addr  in  ADDR_WIDTH  D-cache word address
dc_wdata  in  DATA_WIDTH  write data
dc_wmask  in  DATA_WIDTH/8  byte-enable for writes
dc_done  out  1  1-cycle pulse: D-cache op complete
dc_rdata  out  DATA_WIDTH  read data, valid with dc_done
mem_req  out  1  op outstanding to memory
mem_we  out  1  write enable
mem_addr  out  ADDR_WIDTH  address
mem_wdata  out  DATA_WIDTH  write data
mem_wmask  out  DATA_WIDTH/8  byte mask
mem_done  in  1  1-cycle pulse: memory finished the current op
mem_rdata  in  DATA_WIDTH  read data, valid with mem_done
busy_owner  out  1  0 = I-cache, 1 = D-cache; valid while mem_req=1

States: ARB, BUSY. All mem_* command outputs are registered.

Behaviour:
- Reset:
  - state=ARB; mem_req, mem_we, ic_done, dc_done = 0; mem_addr, mem_wdata, mem_wmask, ic_rdata, dc_rdata, busy_owner = 0.
  - last_grant=D-cache, so the I-cache wins the first tie; burst_cnt=0; lock=0.
  - Reset mid-op abandons the op and produces no done pulse; memory is reset alongside.
- ARB, no request: stay in ARB; mem_req=0.
- ARB, with a request, choose owner:
  - If lock=1 and the locked owner's req=1:
    - burst_cnt<MAX_BURST → grant the locked owner, burst_cnt+1.
    - burst_cnt==MAX_BURST and the other req=1 → grant the other, burst_cnt=1.
    - burst_cnt==MAX_BURST and the other req=0 → grant the locked owner, burst_cnt=1.
  - Otherwise (lock=0, or the locked owner's req=0): a single requester wins. On a tie the requester not equal to last_grant wins; burst_cnt=1.
- On grant, at the ARB→BUSY edge:
  - Latch owner's address, we, wdata, wmask into mem_*; mem_req=1; busy_owner=owner; last_grant=owner; lock=1.
  - I-cache ops always have mem_we=0 and mem_wmask=0.
- Latency: request seen in ARB cycle T → mem_req high from T+1 until the cycle after mem_done.
- BUSY: mem_* held stable; the arbiter ignores ic_*/dc_* changes.
- mem_done in BUSY cycle D:
  - Next edge: state=ARB, mem_req=0.
  - The owner's done pulses for one cycle at D+1, with rdata=registered mem_rdata. The other side's done stays 0.
- Requester contract:
  - Keep req high, with stable fields, until its done.
  - In the cycle done is high, either drop req or present the next op (e.g. next refill word).
  - Minimum op spacing is one ARB cycle: op n done at D+1, op n+1 mem_req at D+2 at the earliest.
- Abort: if the owner drops req while BUSY (e.g. I-cache refill cancelled), the memory op still runs to mem_done. Its done pulse is suppressed and lock is cleared.
- mem_done in ARB (spurious): ignored, no done pulse.
- The counter never wraps: burst_cnt saturates at MAX_BURST.

Test Plan:
- Single D-cache write: dc_req=1, we=1, addr=0x100, wdata=0xDEADBEEF, wmask=0xF; memory mem_done 3 cycles after mem_req → mem_req=1 with those fields one cycle after dc_req; dc_done pulses once, one cycle after mem_done; ic_done stays 0.
- I-cache 16-word refill, addresses 0x2000..0x203C, D-cache idle, 1-cycle memory → 16 ic_done pulses with rdata matching memory; busy_owner=0 throughout; one ARB cycle between ops.
- Simultaneous first requests out of reset: ic and dc both assert at once → I-cache granted first (last_grant reset = D-cache); D-cache granted next only after the I-cache burst ends or hits MAX_BURST.
- Fairness: I-cache holds req for 20 words, D-cache requests at word 3 → I-cache gets words 1..16, then the D-cache op, then I-cache words 17..20.
- Abort: ic_req drops 1 cycle after grant, memory completes 4 cycles later → no ic_done; next ARB grants a pending dc_req immediately.
- Reset mid-op: rst asserted during BUSY → next cycle mem_req=0, state ARB; a late mem_done produces no done pulse; the first post-reset tie goes to the I-cache.
